// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Round-robin arbiter and sequencer that shares one 16-bit sign-magnitude
//   adder datapath between N_REQ requesters. A granted request is latched,
//   added in the following cycle, and held as a registered response until the
//   consumer accepts it.
//
//   Sub-modules (same file):
//     complement            - sign-magnitude <-> two's complement conversion
//     sixteen_bit_full_adder - 16-bit add with carry in / carry out
//
//   Ports (adder_arbiter):
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     req_valid    per-requester request valid
//     req_ready    per-requester accept (combinational, one-hot or zero)
//     req_a/req_b  operands, slice i is [16*i+15:16*i], sign-magnitude
//     req_cin      per-requester carry-in
//     resp_valid   response available
//     resp_ready   consumer accepts the response
//     resp_id      index of the served requester
//     resp_sum     sign-magnitude result
//     resp_ov/zf/nf/cf  overflow, zero, negative, carry flags
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// complement
//   x[15]=0 passes through; otherwise the magnitude is two's-complemented
//   modulo 2^15 with the sign bit kept. 0x8000 maps to itself.
//   Ports: x (in, 16), y (out, 16)
// -----------------------------------------------------------------------------
module complement (
  input  logic [15:0] x,
  output logic [15:0] y
);

  // Conditional negate of the 15-bit magnitude field.
  always_comb begin
    if (x[15]) begin
      y = {1'b1, (~x[14:0]) + 15'd1};
    end else begin
      y = x;
    end
  end

endmodule

// -----------------------------------------------------------------------------
// sixteen_bit_full_adder
//   {cout, sum} = a + b + cin
//   Ports: a, b (in, 16), cin (in, 1), sum (out, 16), cout (out, 1)
// -----------------------------------------------------------------------------
module sixteen_bit_full_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // 17-bit add so the carry out of bit 15 is kept.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
  end

endmodule

// -----------------------------------------------------------------------------
// adder_arbiter (top)
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_cin,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [15:0]           resp_sum,
  output logic                  resp_ov,
  output logic                  resp_zf,
  output logic                  resp_nf,
  output logic                  resp_cf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  // Latched operation.
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic            cin_q, cin_d;
  logic [IDW-1:0]  id_q, id_d;

  // Response registers.
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [15:0]     resp_sum_q, resp_sum_d;
  logic            ov_q, ov_d;
  logic            zf_q, zf_d;
  logic            nf_q, nf_d;
  logic            cf_q, cf_d;

  // Arbitration results.
  logic            grant_found_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [IDW-1:0]  next_ptr_s;
  logic [IDW:0]    cand_s;

  // Datapath nets.
  logic [15:0]     a2_s, b2_s, s_s, sum_sm_s;
  logic            c16_s;
  logic            ov_s, zf_s, nf_s;

  complement u_comp_a (.x(a_q),  .y(a2_s));
  complement u_comp_b (.x(b_q),  .y(b2_s));

  sixteen_bit_full_adder u_add (
    .a    (a2_s),
    .b    (b2_s),
    .cin  (cin_q),
    .sum  (s_s),
    .cout (c16_s)
  );

  complement u_comp_s (.x(s_s), .y(sum_sm_s));

  // Flags are taken on the two's complement sum, before converting back.
  always_comb begin
    ov_s = (a2_s[15] == b2_s[15]) && (s_s[15] != a2_s[15]);
    zf_s = (s_s == 16'd0);
    nf_s = s_s[15];
  end

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_s >= (IDW+1)'(N_REQ)) begin
        cand_s = cand_s - (IDW+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[IDW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer moves to the requester just after the winner, modulo N_REQ.
  always_comb begin
    if (grant_idx_s == IDW'(N_REQ-1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + IDW'(1);
    end
  end

  // Accept strobe: only in IDLE, only for the winner; held low while in reset.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && grant_found_s && rst_n) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and register-update logic for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    ov_d         = ov_q;
    zf_d         = zf_q;
    nf_d         = nf_q;
    cf_d         = cf_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          a_d     = req_a[{grant_idx_s, 4'b0000} +: 16];
          b_d     = req_b[{grant_idx_s, 4'b0000} +: 16];
          cin_d   = req_cin[grant_idx_s];
          id_d    = grant_idx_s;
          ptr_d   = next_ptr_s;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        resp_sum_d   = sum_sm_s;
        resp_id_d    = id_q;
        ov_d         = ov_s;
        zf_d         = zf_s;
        nf_d         = nf_s;
        cf_d         = c16_s;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // resp_valid is always high here, so resp_ready alone completes it.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      cin_q        <= 1'b0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= 16'd0;
      ov_q         <= 1'b0;
      zf_q         <= 1'b0;
      nf_q         <= 1'b0;
      cf_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      ov_q         <= ov_d;
      zf_q         <= zf_d;
      nf_q         <= nf_d;
      cf_q         <= cf_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_ov    = ov_q;
  assign resp_zf    = zf_q;
  assign resp_nf    = nf_q;
  assign resp_cf    = cf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Directed bench for adder_arbiter with N_REQ=4. Inputs are driven and
//   outputs sampled 1-2 time units after the rising edge.
//   Flags are compared as the packed vector {ov, zf, nf, cf}.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_cin;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [15:0]     resp_sum;
  logic            resp_ov, resp_zf, resp_nf, resp_cf;
  logic [3:0]      flags;

  logic [15:0]     a_arr [N];
  logic [15:0]     b_arr [N];

  int errors;
  int checks;

  adder_arbiter #(.N_REQ(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_ov    (resp_ov),
    .resp_zf    (resp_zf),
    .resp_nf    (resp_nf),
    .resp_cf    (resp_cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester operand arrays onto the flat buses.
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = a_arr[i];
      req_b[16*i +: 16] = b_arr[i];
    end
  end

  assign flags = {resp_ov, resp_zf, resp_nf, resp_cf};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on requester idx and collect its response.
  // lat = edges after the accept edge until resp_valid is seen (bounded).
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [N-1:0] rdy, output int lat,
                        output logic [IDW-1:0] id, output logic [15:0] sum,
                        output logic [3:0] flg);
    a_arr[idx]     = a;
    b_arr[idx]     = b;
    req_cin[idx]   = cin;
    req_valid[idx] = 1'b1;
    #1;
    rdy = req_ready;
    tick();
    req_valid[idx] = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    id  = resp_id;
    sum = resp_sum;
    flg = flags;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_cin    = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 16'd0;
      b_arr[i] = 16'd0;
    end
    tick();
    tick();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready got=%b exp=%b", req_ready, 4'b0000);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    checks++;
    if (resp_id !== 2'd0 || resp_sum !== 16'h0000 || flags !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got id=%0d sum=%h flags=%b exp id=0 sum=0000 flags=0000",
                         resp_id, resp_sum, flags);
    end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [N-1:0] rdy; int lat; logic [IDW-1:0] id; logic [15:0] sum; logic [3:0] flg;
    run_op(0, 16'h0001, 16'h0002, 1'b1, rdy, lat, id, sum, flg);
    checks++;
    if (rdy !== 4'b0001) begin
      errors++; $display("FAIL basic_ready got=%b exp=0001", rdy);
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL basic_latency got=%0d exp=1", lat);
    end
    checks++;
    if (id !== 2'd0 || sum !== 16'h0004 || flg !== 4'b0000) begin
      errors++; $display("FAIL basic_resp got id=%0d sum=%h flags=%b exp id=0 sum=0004 flags=0000",
                         id, sum, flg);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_handshake_clear got=%b exp=0", resp_valid);
    end
  endtask

  task automatic test_negative();
    logic [N-1:0] rdy; int lat; logic [IDW-1:0] id; logic [15:0] sum; logic [3:0] flg;
    // -1 + -2 = -3, two's complement add carries out.
    run_op(1, 16'h8001, 16'h8002, 1'b0, rdy, lat, id, sum, flg);
    checks++;
    if (rdy !== 4'b0010 || lat !== 1) begin
      errors++; $display("FAIL neg_grant got rdy=%b lat=%0d exp rdy=0010 lat=1", rdy, lat);
    end
    checks++;
    if (id !== 2'd1 || sum !== 16'h8003 || flg !== 4'b0011) begin
      errors++; $display("FAIL neg_resp got id=%0d sum=%h flags=%b exp id=1 sum=8003 flags=0011",
                         id, sum, flg);
    end
  endtask

  task automatic test_overflow_zero();
    logic [N-1:0] rdy; int lat; logic [IDW-1:0] id; logic [15:0] sum; logic [3:0] flg;
    run_op(2, 16'h7FFF, 16'h0001, 1'b0, rdy, lat, id, sum, flg);
    checks++;
    if (id !== 2'd2 || sum !== 16'h8000 || flg !== 4'b1010) begin
      errors++; $display("FAIL overflow_resp got id=%0d sum=%h flags=%b exp id=2 sum=8000 flags=1010",
                         id, sum, flg);
    end
    run_op(3, 16'h0001, 16'h8001, 1'b0, rdy, lat, id, sum, flg);
    checks++;
    if (id !== 2'd3 || sum !== 16'h0000 || flg !== 4'b0101) begin
      errors++; $display("FAIL zero_resp got id=%0d sum=%h flags=%b exp id=3 sum=0000 flags=0101",
                         id, sum, flg);
    end
  endtask

  task automatic test_round_robin();
    int          order   [5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_sum [5] = '{16'h0030, 16'h0102, 16'h800C, 16'h0000, 16'h8002};
    logic [3:0]  exp_flg [5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0101, 4'b0010};
    logic [N-1:0] exp_rdy;
    // Restart from reset so the pointer is 0.
    rst_n = 1'b0;
    tick();
    a_arr[0] = 16'h0010; b_arr[0] = 16'h0020; req_cin[0] = 1'b0;
    a_arr[1] = 16'h0100; b_arr[1] = 16'h0001; req_cin[1] = 1'b1;
    a_arr[2] = 16'h8010; b_arr[2] = 16'h0004; req_cin[2] = 1'b0;
    a_arr[3] = 16'h0003; b_arr[3] = 16'h8003; req_cin[3] = 1'b0;
    req_valid = 4'b1111;
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      exp_rdy = 4'b0001 << order[g];
      checks++;
      if (!$onehot0(req_ready) || req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, exp_rdy);
      end
      tick();
      if (g == 0) begin
        // Requester 0 re-requests with new operands: -5 + 3 = -2.
        a_arr[0] = 16'h8005; b_arr[0] = 16'h0003; req_cin[0] = 1'b0;
      end else begin
        req_valid[order[g]] = 1'b0;
      end
      #1;
      checks++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL rr_exec%0d got rdy=%b rv=%b exp rdy=0000 rv=0", g, req_ready, resp_valid);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== IDW'(order[g]) || resp_sum !== exp_sum[g] ||
          flags !== exp_flg[g] || req_ready !== 4'b0000) begin
        errors++; $display("FAIL rr_resp%0d got rv=%b id=%0d sum=%h flags=%b rdy=%b exp rv=1 id=%0d sum=%h flags=%b rdy=0000",
                           g, resp_valid, resp_id, resp_sum, flags, req_ready, order[g], exp_sum[g], exp_flg[g]);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [15:0] held_sum;
    // Pointer is 1 after the round-robin run.
    a_arr[1] = 16'h0002; b_arr[1] = 16'h0003; req_cin[1] = 1'b0;
    a_arr[2] = 16'h0004; b_arr[2] = 16'h0004; req_cin[2] = 1'b1;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant got=%b exp=0010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    tick();
    held_sum = resp_sum;
    checks++;
    if (resp_valid !== 1'b1 || resp_sum !== 16'h0005 || resp_id !== 2'd1) begin
      errors++; $display("FAIL bp_first got rv=%b id=%0d sum=%h exp rv=1 id=1 sum=0005", resp_valid, resp_id, resp_sum);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_sum !== held_sum || resp_id !== 2'd1 ||
          flags !== 4'b0000 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d got rv=%b id=%0d sum=%h flags=%b rdy=%b exp rv=1 id=1 sum=%h flags=0000 rdy=0000",
                           c, resp_valid, resp_id, resp_sum, flags, req_ready, held_sum);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_release got rv=%b rdy=%b exp rv=0 rdy=0100", resp_valid, req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 16'h0009 || flags !== 4'b0000) begin
      errors++; $display("FAIL bp_next got rv=%b id=%0d sum=%h flags=%b exp rv=1 id=2 sum=0009 flags=0000",
                         resp_valid, resp_id, resp_sum, flags);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Pointer is 3 here, so requester 3 wins first.
    a_arr[1] = 16'h0002; b_arr[1] = 16'h0003; req_cin[1] = 1'b0;
    a_arr[3] = 16'h0010; b_arr[3] = 16'h0001; req_cin[3] = 1'b0;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL rst_pre_grant got=%b exp=1000", req_ready);
    end
    tick();
    // In EXEC now.
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0000 || resp_sum !== 16'h0000 ||
        resp_id !== 2'd0 || flags !== 4'b0000) begin
      errors++; $display("FAIL rst_exec got rv=%b rdy=%b id=%0d sum=%h flags=%b exp all zero",
                         resp_valid, req_ready, resp_id, resp_sum, flags);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL rst_exec_regrant got=%b exp=0010", req_ready);
    end
    tick();
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 16'h0005) begin
      errors++; $display("FAIL rst_resp_pre got rv=%b id=%0d sum=%h exp rv=1 id=1 sum=0005", resp_valid, resp_id, resp_sum);
    end
    // In RESP with a pending response.
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0000 || resp_sum !== 16'h0000 ||
        resp_id !== 2'd0 || flags !== 4'b0000) begin
      errors++; $display("FAIL rst_resp got rv=%b rdy=%b id=%0d sum=%h flags=%b exp all zero",
                         resp_valid, req_ready, resp_id, resp_sum, flags);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL rst_resp_regrant got=%b exp=0010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 16'h0005 || flags !== 4'b0000) begin
      errors++; $display("FAIL rst_after_resp got rv=%b id=%0d sum=%h flags=%b exp rv=1 id=1 sum=0005 flags=0000",
                         resp_valid, resp_id, resp_sum, flags);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_negative();
    test_overflow_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
